// File: rtl/rns_converter.sv
// Three-stage binary-to-residue converter: a_input mod MODULUS via chunked folding and Barrett reduction.
// Optional RNS_VALID_EN adds an in_valid/out_valid sideband that moves in lockstep with the data.
module rns_converter #(
  parameter int unsigned LWIDTH  = 64,
  parameter int unsigned SWIDTH  = 16,
  parameter int unsigned MODULUS = 65521
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LWIDTH-1:0] a_input,
`ifdef RNS_VALID_EN
  input  logic              in_valid,
  output logic              out_valid,
`endif
  output logic [SWIDTH-1:0] b_output
);

  localparam int unsigned N     = (LWIDTH + SWIDTH - 1) / SWIDTH;
  localparam int unsigned PADW  = N * SWIDTH;
  localparam int unsigned SUMW  = 2 * SWIDTH + $clog2(N);
  localparam int unsigned MUW   = SUMW + 1;
  localparam int unsigned PRODW = SUMW + MUW;

  localparam longint unsigned MOD_L = 64'(MODULUS);
  localparam logic [SUMW-1:0] MOD_S = SUMW'(MODULUS);

  if (MODULUS < 2 || (MOD_L >> SWIDTH) != 64'd0) begin : g_bad_modulus
    $error("rns_converter: MODULUS must satisfy 1 < MODULUS < 2**SWIDTH");
  end

  // K_i = 2^(i*SWIDTH) mod MODULUS, packed chunk i at bits [i*SWIDTH +: SWIDTH].
  function automatic logic [PADW-1:0] gen_k();
    logic [PADW-1:0]  tab;
    longint unsigned  r;
    tab = '0;
    r   = 64'd1;
    for (int unsigned i = 0; i < N; i++) begin
      tab[i*SWIDTH +: SWIDTH] = SWIDTH'(r);
      for (int unsigned j = 0; j < SWIDTH; j++) begin
        r = r << 1;
        if (r >= MOD_L) r = r - MOD_L;
      end
    end
    return tab;
  endfunction

  localparam logic [PADW-1:0] K_TAB = gen_k();

  // Barrett factor floor(2^SUMW / q); since S < 2^SUMW the quotient estimate is short by at most one.
  localparam logic [MUW-1:0] BAR_POW = MUW'(1) << SUMW;
  localparam logic [MUW-1:0] BAR_M   = BAR_POW / MUW'(MODULUS);

  logic [LWIDTH-1:0] r_a;
  logic [SUMW-1:0]   r_s;
  logic [SWIDTH-1:0] r_b;

  logic [PADW-1:0]   w_pad;
  logic [SUMW-1:0]   w_sum;
  logic [SUMW-1:0]   w_qhat;
  logic [SUMW-1:0]   w_qq;
  logic [SUMW-1:0]   w_rem;
  logic [SWIDTH-1:0] w_res;

  always_comb begin
    w_pad              = '0;
    w_pad[LWIDTH-1:0]  = r_a;
    w_sum              = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_sum = w_sum + SUMW'(w_pad[i*SWIDTH +: SWIDTH]) * SUMW'(K_TAB[i*SWIDTH +: SWIDTH]);
    end
  end

  always_comb begin
    w_qhat = SUMW'((PRODW'(r_s) * PRODW'(BAR_M)) >> SUMW);
    w_qq   = w_qhat * MOD_S;
    w_rem  = r_s - w_qq;
    w_res  = SWIDTH'((w_rem >= MOD_S) ? (w_rem - MOD_S) : w_rem);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a <= '0;
      r_s <= '0;
      r_b <= '0;
    end else begin
      r_a <= a_input;
      r_s <= w_sum;
      r_b <= w_res;
    end
  end

  assign b_output = r_b;

`ifdef RNS_VALID_EN
  logic [2:0] r_v;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v <= '0;
    end else begin
      r_v <= {r_v[1:0], in_valid};
    end
  end

  assign out_valid = r_v[2];
`endif

endmodule

// File: tb/tb_rns_converter.sv
// Self-checking bench for rns_converter: vector table plus random stream through a latency scoreboard,
// with hand-written reset sequences.
module tb_rns_converter;

  localparam int unsigned     LW = 64;
  localparam int unsigned     SW = 16;
  localparam longint unsigned Q  = 65521;

  logic          clk = 1'b0;
  logic          reset;
  logic [LW-1:0] a_input;
  logic [SW-1:0] b_output;
`ifdef RNS_VALID_EN
  logic          in_valid;
  logic          out_valid;
`endif

  rns_converter #(
    .LWIDTH (LW),
    .SWIDTH (SW),
    .MODULUS(int'(Q))
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .a_input  (a_input),
`ifdef RNS_VALID_EN
    .in_valid (in_valid),
    .out_valid(out_valid),
`endif
    .b_output (b_output)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        vld;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [15:0] exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[14];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Pipeline after reset holds three zeros, which must emerge as residue 0 with no valid.
  task automatic flush_sb();
    sb.delete();
    repeat (3) sb.push_back('{res: 16'd0, vld: 1'b0});
  endtask

  // Called at a falling edge: check what the pipeline now presents, then drive the next operand.
  task automatic tick(input string name, input logic [63:0] a, input logic [15:0] exp,
                      input logic vld);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got 0 entries, required 3", name);
    end else begin
      e = sb.pop_front();
      check({name, " b_output"}, 64'(b_output), 64'(e.res));
`ifdef RNS_VALID_EN
      check({name, " out_valid"}, 64'(out_valid), 64'(e.vld));
`endif
    end
`ifdef RNS_VALID_EN
    in_valid = vld;
`endif
    a_input = a;
    sb.push_back('{res: exp, vld: vld});
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] ra;

    vecs[0]  = '{64'd0,                    16'd0};
    vecs[1]  = '{64'd29,                   16'd29};
    vecs[2]  = '{64'd65521,                16'd0};
    vecs[3]  = '{64'd65536,                16'd15};
    vecs[4]  = '{64'hFFFF_FFFF_FFFF_FFFF,  16'd50624};
    vecs[5]  = '{64'h0000_0001_0000_0000,  16'd225};
    vecs[6]  = '{64'h0001_0000_0000_0000,  16'd3375};
    vecs[7]  = '{64'd65520,                16'd65520};
    vecs[8]  = '{64'd65522,                16'd1};
    vecs[9]  = '{64'd131042,               16'd0};
    vecs[10] = '{64'd65535,                16'd14};
    vecs[11] = '{64'h0000_0000_FFFF_FFFF,  16'd224};
    vecs[12] = '{64'h0000_FFFF_FFFF_FFFF,  16'd3374};
    vecs[13] = '{64'd1,                    16'd1};

    reset   = 1'b0;
    a_input = 64'h1234_5678_9ABC_DEF0;
`ifdef RNS_VALID_EN
    in_valid = 1'b1;
`endif
    @(negedge clk);
    check("in_reset_1", 64'(b_output), 64'd0);
    @(negedge clk);
    check("in_reset_2", 64'(b_output), 64'd0);
`ifdef RNS_VALID_EN
    check("in_reset_valid", 64'(out_valid), 64'd0);
`endif

    a_input = 64'd0;
    reset   = 1'b1;
    flush_sb();
    for (int i = 0; i < 14; i++) begin
      tick($sformatf("vec%0d", i), vecs[i].a, vecs[i].exp, 1'b1);
    end
    for (int i = 0; i < 16; i++) begin
      ra = {$urandom, $urandom};
      tick($sformatf("rand%0d", i), ra, 16'(ra % Q), (i % 3) != 0);
    end

    // Asynchronous reset landing between edges with nonzero residues in flight.
    tick("mid_a", 64'hFFFF_FFFF_FFFF_FFFF, 16'd50624, 1'b1);
    tick("mid_b", 64'd65536, 16'd15, 1'b1);
    tick("mid_c", 64'd29, 16'd29, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_now", 64'(b_output), 64'd0);
`ifdef RNS_VALID_EN
    check("async_reset_valid", 64'(out_valid), 64'd0);
`endif
    @(negedge clk);
    check("async_reset_held", 64'(b_output), 64'd0);
    reset = 1'b1;
    flush_sb();
    tick("post_29", 64'd29, 16'd29, 1'b1);
    tick("post_z0", 64'd0, 16'd0, 1'b0);
    tick("post_z1", 64'd0, 16'd0, 1'b0);
    tick("post_z2", 64'd0, 16'd0, 1'b0);
    tick("post_z3", 64'd0, 16'd0, 1'b0);
    tick("post_z4", 64'd0, 16'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
